// File: rtl/cntr_arbiter.sv
// cntr_arbiter: buffers one time-difference count per microphone channel and
// forwards the buffered values round-robin to Top as single-cycle pulses, each
// pulse followed by at least GAP idle cycles and tagged with its channel id.
module cntr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNTR_W = 10,
  parameter int GAP    = 2,
  localparam int ID_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*CNTR_W-1:0] ch_cntr,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     overrun_clr,
  output logic [CNTR_W-1:0]        cntr,
  output logic                     cntr_valid,
  output logic [ID_W-1:0]          cntr_ch,
  output logic [NUM_CH-1:0]        pend,
  output logic [NUM_CH-1:0]        overrun,
  output logic                     busy
);

  localparam logic [3:0] GAP_CNT = 4'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [3:0]        r_gapCnt;
  logic [ID_W-1:0]   r_lastGrant;
  logic [CNTR_W-1:0] r_buf [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_overrun;
  logic [CNTR_W-1:0] r_cntr;
  logic [ID_W-1:0]   r_cntrCh;
  logic              r_cntrValid;

  logic              w_found;
  logic [ID_W-1:0]   w_grant;
  logic              w_grantEn;

  // Pick the first pending channel after the last one served, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!w_found && r_pend[ID_W'((int'(r_lastGrant) + k) % NUM_CH)]) begin
        w_found = 1'b1;
        w_grant = ID_W'((int'(r_lastGrant) + k) % NUM_CH);
      end
    end
    w_grantEn = (r_state == S_IDLE) && w_found;
  end

  // Per-channel buffer: capture into a free slot or into the slot being granted, else flag overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend    <= '0;
      r_overrun <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (overrun_clr) begin
        r_overrun <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          if (!r_pend[i] || (w_grantEn && (w_grant == ID_W'(i)))) begin
            r_buf[i]  <= ch_cntr[i*CNTR_W +: CNTR_W];
            r_pend[i] <= 1'b1;
          end else begin
            r_overrun[i] <= 1'b1;
          end
        end else if (w_grantEn && (w_grant == ID_W'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Grant/issue/gap sequencer that drives the registered output pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_gapCnt    <= '0;
      r_lastGrant <= ID_W'(NUM_CH - 1);
      r_cntr      <= '0;
      r_cntrCh    <= '0;
      r_cntrValid <= 1'b0;
    end else begin
      r_cntrValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grantEn) begin
            r_cntr      <= r_buf[w_grant];
            r_cntrCh    <= w_grant;
            r_lastGrant <= w_grant;
            r_cntrValid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (GAP_CNT == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_GAP;
            r_gapCnt <= GAP_CNT;
          end
        end
        S_GAP: begin
          if (r_gapCnt <= 4'd1) begin
            r_state  <= S_IDLE;
            r_gapCnt <= '0;
          end else begin
            r_gapCnt <= r_gapCnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cntr       = r_cntr;
  assign cntr_valid = r_cntrValid;
  assign cntr_ch    = r_cntrCh;
  assign pend       = r_pend;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cntr_arbiter.sv
// tb_cntr_arbiter: directed scenarios plus a randomized run checked against a
// cycle-count based model of the arbiter (cooldown arithmetic, round-robin search).
module tb_cntr_arbiter;

  localparam int NUM_CH = 4;
  localparam int CNTR_W = 10;
  localparam int GAP    = 2;
  localparam int ID_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_CH*CNTR_W-1:0] ch_cntr = '0;
  logic [NUM_CH-1:0]        ch_valid = '0;
  logic                     overrun_clr = 1'b0;
  logic [CNTR_W-1:0]        cntr;
  logic                     cntr_valid;
  logic [ID_W-1:0]          cntr_ch;
  logic [NUM_CH-1:0]        pend;
  logic [NUM_CH-1:0]        overrun;
  logic                     busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int                mBuf [NUM_CH];
  logic [NUM_CH-1:0] mPend;
  logic [NUM_CH-1:0] mOver;
  int                mLast;
  int                mNext;
  int                mCycle;
  logic              eValid;
  int                eCntr;
  int                eCh;
  logic              eBusy;

  always #5 clk = ~clk;

  cntr_arbiter #(.NUM_CH(NUM_CH), .CNTR_W(CNTR_W), .GAP(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .ch_cntr(ch_cntr),
    .ch_valid(ch_valid),
    .overrun_clr(overrun_clr),
    .cntr(cntr),
    .cntr_valid(cntr_valid),
    .cntr_ch(cntr_ch),
    .pend(pend),
    .overrun(overrun),
    .busy(busy)
  );

  function automatic logic [NUM_CH*CNTR_W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {CNTR_W'(d), CNTR_W'(c), CNTR_W'(b), CNTR_W'(a)};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) mBuf[i] = 0;
    mPend = '0; mOver = '0; mLast = NUM_CH - 1; mNext = 0; mCycle = 0;
    eValid = 1'b0; eCntr = 0; eCh = 0; eBusy = 1'b0;
  endtask

  // One clock edge of the model: a grant is allowed once GAP+2 cycles have passed since the last one.
  task automatic modelStep(input logic [NUM_CH-1:0] v, input logic [NUM_CH*CNTR_W-1:0] d, input logic clr);
    logic [NUM_CH-1:0] oldPend;
    int g;
    oldPend = mPend;
    g = -1;
    if (mCycle >= mNext) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int idx;
        idx = (mLast + k) % NUM_CH;
        if (g < 0 && oldPend[idx]) g = idx;
      end
    end
    eValid = (g >= 0);
    if (g >= 0) begin
      eCntr = mBuf[g]; eCh = g; mLast = g; mNext = mCycle + GAP + 2;
    end
    if (clr) mOver = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) begin
        if (!oldPend[i] || g == i) begin
          mBuf[i] = int'(d[i*CNTR_W +: CNTR_W]); mPend[i] = 1'b1;
        end else begin
          mOver[i] = 1'b1;
        end
      end else if (g == i) begin
        mPend[i] = 1'b0;
      end
    end
    eBusy = (mCycle < mNext - 1);
    mCycle++;
  endtask

  // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic tick(input logic [NUM_CH-1:0] v, input logic [NUM_CH*CNTR_W-1:0] d, input logic clr);
    ch_valid = v; ch_cntr = d; overrun_clr = clr;
    modelStep(v, d, clr);
    @(posedge clk); #1;
    ch_valid = '0; overrun_clr = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ch_valid = NUM_CH'($urandom); ch_cntr = {$urandom, $urandom};
      @(posedge clk); #1;
      vectors++; if (cntr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %0b expected 0", cntr_valid); end
      vectors++; if (cntr !== '0) begin miscompares++; $display("[TB] FAIL reset_cntr: got %0d expected 0", cntr); end
      vectors++; if (pend !== '0 || overrun !== '0 || busy !== 1'b0 || cntr_ch !== '0) begin
        miscompares++; $display("[TB] FAIL reset_state: pend=%b overrun=%b busy=%b ch=%0d expected all 0", pend, overrun, busy, cntr_ch);
      end
    end
    ch_valid = '0;
    rst = 1'b1;
    modelReset();
    tick(4'hF, pack4(11, 22, 33, 44), 1'b0);
    tick('0, '0, 1'b0);
    vectors++; if (cntr_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL first_grant_valid: got %0b expected 1", cntr_valid); end
    vectors++; if (cntr_ch !== 2'd0) begin miscompares++; $display("[TB] FAIL first_grant_ch: got %0d expected 0", cntr_ch); end
    vectors++; if (cntr !== 10'd11) begin miscompares++; $display("[TB] FAIL first_grant_val: got %0d expected 11", cntr); end
  endtask

  task automatic test_single();
    applyReset();
    tick(4'b0010, pack4(0, 800, 0, 0), 1'b0);
    vectors++; if (cntr_valid !== 1'b0 || pend !== 4'b0010) begin
      miscompares++; $display("[TB] FAIL single_capture: valid=%0b pend=%b expected 0/0010", cntr_valid, pend);
    end
    tick('0, '0, 1'b0);
    vectors++; if (cntr_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid: got %0b expected 1", cntr_valid); end
    vectors++; if (cntr !== 10'd800) begin miscompares++; $display("[TB] FAIL single_cntr: got %0d expected 800", cntr); end
    vectors++; if (cntr_ch !== 2'd1) begin miscompares++; $display("[TB] FAIL single_ch: got %0d expected 1", cntr_ch); end
    vectors++; if (pend !== 4'b0000 || overrun !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL single_flags: pend=%b overrun=%b expected 0000/0000", pend, overrun);
    end
    tick('0, '0, 1'b0);
    vectors++; if (cntr_valid !== 1'b0 || cntr !== 10'd800) begin
      miscompares++; $display("[TB] FAIL single_hold: valid=%0b cntr=%0d expected 0/800", cntr_valid, cntr);
    end
  endtask

  task automatic test_round_robin();
    int expCh [4];
    int expVal [4];
    int n;
    int prev;
    expCh = '{0, 1, 2, 3};
    expVal = '{800, 200, 800, 5};
    n = 0; prev = 0;
    applyReset();
    tick(4'hF, pack4(800, 200, 800, 5), 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick('0, '0, 1'b0);
      if (cntr_valid === 1'b1 && n < 4) begin
        vectors++; if (cntr_ch !== ID_W'(expCh[n]) || cntr !== CNTR_W'(expVal[n])) begin
          miscompares++; $display("[TB] FAIL rr_pulse%0d: ch=%0d val=%0d expected ch=%0d val=%0d", n, cntr_ch, cntr, expCh[n], expVal[n]);
        end
        if (n > 0) begin
          vectors++; if (c - prev != GAP + 2) begin
            miscompares++; $display("[TB] FAIL rr_spacing%0d: got %0d expected %0d", n, c - prev, GAP + 2);
          end
        end
        prev = c; n++;
      end
    end
    vectors++; if (n != 4) begin miscompares++; $display("[TB] FAIL rr_count: got %0d expected 4", n); end
  endtask

  task automatic test_overrun();
    int seen;
    seen = 0;
    applyReset();
    tick(4'b0101, pack4(50, 0, 100, 0), 1'b0);
    tick('0, '0, 1'b0);
    tick(4'b0100, pack4(0, 0, 300, 0), 1'b0);
    vectors++; if (overrun !== 4'b0100) begin miscompares++; $display("[TB] FAIL ovr_set: got %b expected 0100", overrun); end
    for (int c = 0; c < 12; c++) begin
      tick('0, '0, 1'b0);
      if (cntr_valid === 1'b1 && seen == 0) begin
        seen = 1;
        vectors++; if (cntr_ch !== 2'd2 || cntr !== 10'd100) begin
          miscompares++; $display("[TB] FAIL ovr_forward: ch=%0d val=%0d expected ch=2 val=100", cntr_ch, cntr);
        end
      end
    end
    vectors++; if (seen != 1 || pend !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL ovr_drain: seen=%0d pend=%b expected 1/0000", seen, pend);
    end
    tick('0, '0, 1'b1);
    vectors++; if (overrun !== 4'b0000) begin miscompares++; $display("[TB] FAIL ovr_clear: got %b expected 0000", overrun); end
  endtask

  task automatic test_recapture();
    int seen;
    seen = 0;
    applyReset();
    tick(4'b1000, pack4(0, 0, 0, 9), 1'b0);
    tick(4'b1000, pack4(0, 0, 0, 7), 1'b0);
    vectors++; if (cntr_valid !== 1'b1 || cntr !== 10'd9 || cntr_ch !== 2'd3) begin
      miscompares++; $display("[TB] FAIL recap_first: valid=%0b val=%0d ch=%0d expected 1/9/3", cntr_valid, cntr, cntr_ch);
    end
    vectors++; if (pend !== 4'b1000 || overrun !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL recap_flags: pend=%b overrun=%b expected 1000/0000", pend, overrun);
    end
    for (int c = 0; c < 10; c++) begin
      tick('0, '0, 1'b0);
      if (cntr_valid === 1'b1 && seen == 0) begin
        seen = 1;
        vectors++; if (cntr !== 10'd7 || cntr_ch !== 2'd3) begin
          miscompares++; $display("[TB] FAIL recap_second: val=%0d ch=%0d expected 7/3", cntr, cntr_ch);
        end
      end
    end
    vectors++; if (seen != 1 || overrun !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL recap_end: seen=%0d overrun=%b expected 1/0000", seen, overrun);
    end
  endtask

  task automatic test_reset_mid_gap();
    int pulses;
    pulses = 0;
    applyReset();
    tick(4'hF, pack4(1, 2, 3, 4), 1'b0);
    tick('0, '0, 1'b0);
    tick('0, '0, 1'b0);
    vectors++; if (pend !== 4'b1110 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL midgap_pre: pend=%b busy=%b expected 1110/1", pend, busy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++; if (pend !== '0 || busy !== 1'b0 || cntr_valid !== 1'b0 || cntr !== '0) begin
      miscompares++; $display("[TB] FAIL midgap_async: pend=%b busy=%b valid=%0b cntr=%0d expected all 0", pend, busy, cntr_valid, cntr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    modelReset();
    for (int c = 0; c < 10; c++) begin
      tick('0, '0, 1'b0);
      if (cntr_valid !== 1'b0) pulses++;
    end
    vectors++; if (pulses != 0 || pend !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL midgap_after: pulses=%0d pend=%b expected 0/0000", pulses, pend);
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0]        v;
    logic [NUM_CH*CNTR_W-1:0] d;
    logic                     clr;
    applyReset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_CH; i++) v[i] = ($urandom_range(0, 3) == 0);
      d = {$urandom, $urandom};
      clr = ($urandom_range(0, 15) == 0);
      tick(v, d, clr);
      vectors++; if (cntr_valid !== eValid) begin miscompares++; $display("[TB] FAIL rnd_valid@%0d: got %0b expected %0b", c, cntr_valid, eValid); end
      vectors++; if (cntr !== CNTR_W'(eCntr)) begin miscompares++; $display("[TB] FAIL rnd_cntr@%0d: got %0d expected %0d", c, cntr, eCntr); end
      vectors++; if (cntr_ch !== ID_W'(eCh)) begin miscompares++; $display("[TB] FAIL rnd_ch@%0d: got %0d expected %0d", c, cntr_ch, eCh); end
      vectors++; if (pend !== mPend) begin miscompares++; $display("[TB] FAIL rnd_pend@%0d: got %b expected %b", c, pend, mPend); end
      vectors++; if (overrun !== mOver) begin miscompares++; $display("[TB] FAIL rnd_overrun@%0d: got %b expected %b", c, overrun, mOver); end
      vectors++; if (busy !== eBusy) begin miscompares++; $display("[TB] FAIL rnd_busy@%0d: got %0b expected %0b", c, busy, eBusy); end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_recapture();
    test_reset_mid_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
